ingress_port: RTL

- Parametrised next-generation router input port: deserialises a serial frame into an address plus one or more DATA_W-bit payload words.
- Buffers whole packets in a commit/rewind circular buffer and presents only complete packets to the central arbiter as a request (vld).
- Adds multi-word packets, truncation/overflow packet drop, and packet/drop statistics.

---
 rtl/router_pkg.sv | 13 +
 rtl/ingress_port_if.sv | 32 +++
 rtl/ingress_buf.sv | 88 ++++++++
 rtl/ingress_port.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types for the router ingress path: deserialiser FSM states.
package router_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    ADDR,
    PAD,
    PAYLOAD,
    DISCARD
  } state_t;

endpackage

// File: rtl/ingress_port_if.sv
// Serial frame input, arbiter request/grant and statistics of one ingress port.
interface ingress_port_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              frame_n;
  logic              valid_n;
  logic              di;
  logic              granted;
  logic              vld;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] payload;
  logic              sop;
  logic              eop;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output frame_n, valid_n, di, granted,
    input  vld, addr, payload, sop, eop, level, pkt_cnt, drop_cnt
  );

  modport slave (
    input  frame_n, valid_n, di, granted,
    output vld, addr, payload, sop, eop, level, pkt_cnt, drop_cnt
  );
endinterface

// File: rtl/ingress_buf.sv
// Circular packet buffer with commit/rewind; head shown fall-through, pop on the grant edge.
// A write and a pop in the same cycle are both applied; full means DEPTH entries incl. uncommitted.
module ingress_buf #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit_wr,
  input  logic              commit_cur,
  input  logic              rewind,
  input  logic              patch_eop,
  input  logic              pop,
  output logic              full,
  output logic              vld,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sop,
  output logic              rd_eop,
  output logic [DATA_W-1:0] rd_data,
  output logic [$clog2(DEPTH):0] level
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   commit_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   last_ptr;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == PW'(DEPTH));
  assign vld      = (rd_ptr != commit_ptr);
  assign last_ptr = wr_ptr - PW'(1);
  assign head     = mem[rd_ptr[IW-1:0]];

  // Storage is never reset, so the head fields are masked while nothing is committed.
  assign rd_addr = vld ? head.addr : '0;
  assign rd_sop  = vld & head.sop;
  assign rd_eop  = vld & head.eop;
  assign rd_data = vld ? head.data : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rewind) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (commit_wr) begin
        commit_ptr <= wr_ptr + PW'(1);
      end else if (commit_cur) begin
        commit_ptr <= wr_ptr;
      end
      if (pop && vld) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr[IW-1:0]] <= '{addr: wr_addr, sop: wr_sop, eop: wr_eop, data: wr_data};
    end
    if (patch_eop) begin
      mem[last_ptr[IW-1:0]].eop <= 1'b1;
    end
  end

endmodule

// File: rtl/ingress_port.sv
// Router input port: deserialises address + payload words, commits whole packets, 1-cycle commit-to-vld.
// Arbiter pops the head via granted; a full buffer drops the packet being received (no stall upstream).
module ingress_port
  import router_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int PAD_CYC = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input logic           clock,
  input logic           reset_n,
  ingress_port_if.slave bus
);
  localparam int CMAX  = (DATA_W > 16) ? DATA_W : 16;
  localparam int BIT_W = $clog2(CMAX);
  localparam state_t AFTER_ADDR = (PAD_CYC == 0) ? PAYLOAD : PAD;

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt, shifted;
  logic              first_q, first_nxt;
  logic [CNT_W-1:0]  pkt_cnt_q, drop_cnt_q;
  logic              wr_en, wr_eop, commit_wr, commit_cur, patch_eop;
  logic              pkt_inc, drop_inc, full;

  assign shifted = data_q | (DATA_W'(bus.di) << bit_cnt);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    first_nxt   = first_q;
    wr_en       = 1'b0;
    wr_eop      = 1'b0;
    commit_wr   = 1'b0;
    commit_cur  = 1'b0;
    patch_eop   = 1'b0;
    pkt_inc     = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      WAIT_IDLE: if (bus.frame_n) state_nxt = IDLE;
      IDLE: begin
        if (!bus.frame_n) begin
          addr_nxt    = ADDR_W'(bus.di);
          data_nxt    = '0;
          first_nxt   = 1'b1;
          bit_cnt_nxt = (ADDR_W == 1) ? '0 : BIT_W'(1);
          state_nxt   = (ADDR_W == 1) ? AFTER_ADDR : ADDR;
        end
      end
      ADDR: begin
        addr_nxt = addr_q | (ADDR_W'(bus.di) << bit_cnt);
        if (bus.frame_n) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end else if (bit_cnt == BIT_W'(ADDR_W - 1)) begin
          bit_cnt_nxt = '0;
          state_nxt   = AFTER_ADDR;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      PAD: begin
        if (bus.frame_n) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end else if (bit_cnt == BIT_W'(PAD_CYC - 1)) begin
          bit_cnt_nxt = '0;
          state_nxt   = PAYLOAD;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      PAYLOAD: begin
        if (!bus.valid_n) begin
          data_nxt = shifted;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            bit_cnt_nxt = '0;
            data_nxt    = '0;
            if (full) begin
              drop_inc  = 1'b1;
              state_nxt = bus.frame_n ? IDLE : DISCARD;
            end else begin
              wr_en     = 1'b1;
              wr_eop    = bus.frame_n;
              first_nxt = 1'b0;
              if (bus.frame_n) begin
                commit_wr = 1'b1;
                pkt_inc   = 1'b1;
                state_nxt = IDLE;
              end
            end
          end else if (bus.frame_n) begin
            drop_inc  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end else if (bus.frame_n) begin
          // Frame closed on a stall: only legal on a word boundary; eop goes onto the word already stored.
          if (bit_cnt == '0 && !first_q) begin
            patch_eop  = 1'b1;
            commit_cur = 1'b1;
            pkt_inc    = 1'b1;
          end else begin
            drop_inc = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      DISCARD: if (bus.frame_n) state_nxt = IDLE;
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_IDLE;
      bit_cnt    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      first_q    <= 1'b1;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      first_q <= first_nxt;
      if (pkt_inc && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pkt_cnt  = pkt_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;

  ingress_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (addr_q),
    .wr_sop     (first_q),
    .wr_eop     (wr_eop),
    .wr_data    (shifted),
    .commit_wr  (commit_wr),
    .commit_cur (commit_cur),
    .rewind     (drop_inc),
    .patch_eop  (patch_eop),
    .pop        (bus.granted),
    .full       (full),
    .vld        (bus.vld),
    .rd_addr    (bus.addr),
    .rd_sop     (bus.sop),
    .rd_eop     (bus.eop),
    .rd_data    (bus.payload),
    .level      (bus.level)
  );

endmodule
